// File: rtl/lif_neuron_array.sv
// Array of N leaky integrate-and-fire neurons stepped in parallel on each enabled clock,
// with refractory counters, two reset modes and a saturating population spike counter.
module lif_neuron_array #(
  parameter int unsigned N          = 4,
  parameter int unsigned W          = 8,
  parameter int unsigned LEAK_SHIFT = 4,
  parameter int unsigned RW         = 4,
  parameter int unsigned CW         = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic [N*W-1:0]                     current,
  input  logic [W-1:0]                       threshold,
  input  logic                               mode,
  input  logic [RW-1:0]                      refrac_len,
  input  logic                               clr_cnt,
  input  logic [$clog2((N > 1) ? N : 2)-1:0] sel,
  output logic [N-1:0]                       spike,
  output logic [W-1:0]                       state_sel,
  output logic [CW-1:0]                      spike_count
);

  localparam int unsigned SW = $clog2((N > 1) ? N : 2);
  localparam int unsigned PW = $clog2(N + 1);
  localparam logic [CW+PW-1:0] CntMax = {{PW{1'b0}}, {CW{1'b1}}};

  logic [W-1:0]     state_q [N];
  logic [W-1:0]     state_d [N];
  logic [RW-1:0]    refr_q  [N];
  logic [RW-1:0]    refr_d  [N];
  logic [N-1:0]     spike_q, spike_d;
  logic [CW-1:0]    count_q, count_d;
  logic [W:0]       leak, v;
  logic [PW-1:0]    pop;
  logic [CW+PW-1:0] sum;

  always_comb begin
    spike_d = '0;
    pop     = '0;
    leak    = '0;
    v       = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      refr_d[i]  = refr_q[i];
      if (en) begin
        if (refr_q[i] != '0) begin
          refr_d[i] = refr_q[i] - 1'b1;
        end else begin
          leak = (LEAK_SHIFT != 0) ? {1'b0, state_q[i] >> LEAK_SHIFT} : '0;
          // Leak never exceeds the state, so only the upper end can overflow.
          v = {1'b0, state_q[i]} - leak + {1'b0, current[i*W +: W]};
          if (v[W]) begin
            v = {1'b0, {W{1'b1}}};
          end
          if ((threshold != '0) && (v >= {1'b0, threshold})) begin
            spike_d[i] = 1'b1;
            state_d[i] = mode ? (v[W-1:0] - threshold) : '0;
            refr_d[i]  = refrac_len;
          end else begin
            state_d[i] = v[W-1:0];
          end
        end
      end
      pop = pop + PW'(spike_d[i]);
    end

    sum = {{PW{1'b0}}, count_q} + {{CW{1'b0}}, pop};
    if (clr_cnt) begin
      count_d = '0;
    end else if (sum > CntMax) begin
      count_d = {CW{1'b1}};
    end else begin
      count_d = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= '0;
        refr_q[i]  <= '0;
      end
      spike_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        refr_q[i]  <= refr_d[i];
      end
      spike_q <= spike_d;
      count_q <= count_d;
    end
  end

  // Out-of-range selects match no neuron and read as zero.
  always_comb begin
    state_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        state_sel = state_q[i];
      end
    end
  end

  assign spike       = spike_q;
  assign spike_count = count_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Drives two neuron arrays (no leak / 4-bit counter, and leak shift 4 / 16-bit counter)
// with directed and random steps, checking both against an integer reference model.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] current = '0;
  logic [7:0]  threshold = '0;
  logic        mode = 1'b0;
  logic [3:0]  refrac_len = '0;
  logic        clr_cnt = 1'b0;
  logic [1:0]  sel = '0;

  logic [3:0]  spike_a, spike_b;
  logic [7:0]  state_sel_a, state_sel_b;
  logic [3:0]  count_a;
  logic [15:0] count_b;

  int total = 0;
  int bad = 0;

  int ms [2][4];
  int mr [2][4];
  int mc [2];
  int msp [2];
  int lk [2] = '{0, 4};
  int cmax [2] = '{15, 65535};

  always #5 clk = ~clk;

  lif_neuron_array #(.N(4), .W(8), .LEAK_SHIFT(0), .RW(4), .CW(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .threshold(threshold),
    .mode(mode), .refrac_len(refrac_len), .clr_cnt(clr_cnt), .sel(sel),
    .spike(spike_a), .state_sel(state_sel_a), .spike_count(count_a)
  );

  lif_neuron_array #(.N(4), .W(8), .LEAK_SHIFT(4), .RW(4), .CW(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .current(current), .threshold(threshold),
    .mode(mode), .refrac_len(refrac_len), .clr_cnt(clr_cnt), .sel(sel),
    .spike(spike_b), .state_sel(state_sel_b), .spike_count(count_b)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        ms[k][i] = 0;
        mr[k][i] = 0;
      end
      mc[k]  = 0;
      msp[k] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      int fired = 0;
      for (int i = 0; i < 4; i++) begin
        if (!en) continue;
        if (mr[k][i] > 0) begin
          mr[k][i]--;
        end else begin
          int s = ms[k][i];
          int c = int'(current[i*8 +: 8]);
          int v = s - ((lk[k] != 0) ? (s >> lk[k]) : 0) + c;
          if (v > 255) v = 255;
          if (threshold != 0 && v >= int'(threshold)) begin
            fired += 1 << i;
            ms[k][i] = mode ? v - int'(threshold) : 0;
            mr[k][i] = int'(refrac_len);
          end else begin
            ms[k][i] = v;
          end
        end
      end
      msp[k] = fired;
      if (clr_cnt) mc[k] = 0;
      else begin
        mc[k] = mc[k] + $countones(fired[3:0]);
        if (mc[k] > cmax[k]) mc[k] = cmax[k];
      end
    end
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".spk_a"}, 32'(spike_a), 32'(msp[0]));
    chk({tag, ".spk_b"}, 32'(spike_b), 32'(msp[1]));
    chk({tag, ".cnt_a"}, 32'(count_a), 32'(mc[0]));
    chk({tag, ".cnt_b"}, 32'(count_b), 32'(mc[1]));
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      chk($sformatf("%s.st_a%0d", tag, i), 32'(state_sel_a), 32'(ms[0][i]));
      chk($sformatf("%s.st_b%0d", tag, i), 32'(state_sel_b), 32'(ms[1][i]));
    end
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Hand-derived expectation for one neuron, independent of the model.
  task automatic cst(string tag, int k, int n, int es, int esp);
    sel = 2'(n);
    #1;
    chk({tag, ".st"}, 32'((k != 0) ? state_sel_b : state_sel_a), 32'(es));
    chk({tag, ".spk"}, 32'((k != 0) ? spike_b[n] : spike_a[n]), 32'(esp));
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset("por");

    // Integrate to threshold with reset-to-zero, period of four steps.
    threshold = 8'd100; mode = 1'b0; refrac_len = 4'd0; current = 32'd30; en = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick("integ");
      cst($sformatf("integ_c%0d", t), 0, 0, ((t % 4) == 3) ? 0 : 30 * (t % 4 + 1),
          ((t % 4) == 3) ? 1 : 0);
    end

    // Saturation without firing.
    do_reset("rst_sat");
    threshold = 8'd0; current = 32'd255; en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick("sat");
      cst("sat_c", 0, 0, 255, 0);
    end

    // Leak on the shifted array: 160 -> 150 -> 141 -> 133.
    do_reset("rst_leak");
    threshold = 8'd0; current = 32'd160;
    tick("leak_load");
    cst("leak_c0", 1, 0, 160, 0);
    current = 32'd0;
    tick("leak1"); cst("leak_c1", 1, 0, 150, 0);
    tick("leak2"); cst("leak_c2", 1, 0, 141, 0);
    tick("leak3"); cst("leak_c3", 1, 0, 133, 0);

    // Subtract mode: 90 + 30 = 120 fires and keeps 20.
    do_reset("rst_sub");
    threshold = 8'd100; mode = 1'b1; current = 32'd90;
    tick("sub_load");
    current = 32'd30;
    tick("sub_fire");
    cst("sub_c", 0, 0, 20, 1);

    // Refractory: fire, hold two enabled steps (en=0 step in between), then fire again.
    do_reset("rst_ref");
    threshold = 8'd50; mode = 1'b0; refrac_len = 4'd2; current = 32'd60;
    tick("ref0"); cst("ref_c0", 0, 0, 0, 1);
    tick("ref1"); cst("ref_c1", 0, 0, 0, 0);
    en = 1'b0;
    tick("ref_off"); cst("ref_c2", 0, 0, 0, 0);
    en = 1'b1;
    tick("ref2"); cst("ref_c3", 0, 0, 0, 0);
    tick("ref3"); cst("ref_c4", 0, 0, 0, 1);

    // Population: all fire each step; 4-bit counter saturates, clear drops same-cycle spikes.
    do_reset("rst_pop");
    threshold = 8'd100; refrac_len = 4'd0; current = {4{8'd200}};
    for (int t = 0; t < 5; t++) begin
      tick("pop");
      chk("pop_spk_c", 32'(spike_a), 32'hF);
      chk("pop_cnt_c", 32'(count_a), (t < 3) ? 32'(4 * (t + 1)) : 32'd15);
      chk("pop_cntb_c", 32'(count_b), 32'(4 * (t + 1)));
    end
    clr_cnt = 1'b1;
    tick("pop_clr");
    chk("clr_cnt_c", 32'(count_b), 32'd0);
    clr_cnt = 1'b0;
    tick("pop_after");
    do_reset("rst_mid");

    // Random steps against the model.
    for (int t = 0; t < 400; t++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 4; i++) begin
        current[i*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                                         : 8'($urandom_range(0, 60));
      end
      threshold  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      mode       = 1'($urandom_range(0, 1));
      refrac_len = 4'($urandom_range(0, 3));
      clr_cnt    = ($urandom_range(0, 15) == 0);
      tick("rnd");
      if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
